axi_ram_bridge: RTL and testbench



---
 rtl/axi_pkg.sv | 33 +++
 rtl/strb2mask.sv | 14 +
 rtl/axi_ram_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_axi_ram_bridge.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared definitions for the AXI4-Lite to RAM bridge.
// Holds the response codes, the read/write FSM state encodings and the
// address range helper used by both channels.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Read FSM states
  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_ACCESS = 2'd1;
  localparam logic [1:0] R_RESP   = 2'd2;

  // Write FSM states
  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_ISSUE = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  // True iff base <= addr <= base + size - 8. Done in 33 bits so that
  // base + size cannot wrap around the 32-bit address space.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + {1'b0, size} - 33'd8;
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/strb2mask.sv
// Expands 8 byte strobes into a 64-bit bit mask.
// Ports:
//   strb  in  8   byte strobes, bit i covers byte i
//   mask  out 64  mask[8i+7:8i] = {8{strb[i]}}
module strb2mask (
  input  logic [7:0]  strb,
  output logic [63:0] mask
);

  for (genvar i = 0; i < 8; i++) begin : g_byte
    assign mask[8*i +: 8] = {8{strb[i]}};
  end

endmodule

// File: rtl/axi_ram_bridge.sv
// AXI4-Lite slave translating CPU reads/writes into the flat ram port protocol.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   ar*/r*                         AXI read address / read data channels
//   aw*/w*/b*                      AXI write address / data / response channels
//   ram_ren_o, ram_raddr_o         RAM read strobe and address
//   ram_rdata_i                    RAM read data (combinational from ram)
//   ram_wen_o, ram_waddr_o,        RAM write strobe, address,
//   ram_wdata_o, ram_wmask_o       pre-masked data and bit mask
// Writes take priority over reads so that a read always sees completed writes.
module axi_ram_bridge
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h8000_0000,
  parameter logic [31:0] SIZE = 32'h0080_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        ram_ren_o,
  output logic [31:0] ram_raddr_o,
  input  logic [63:0] ram_rdata_i,
  output logic        ram_wen_o,
  output logic [31:0] ram_waddr_o,
  output logic [63:0] ram_wdata_o,
  output logic [63:0] ram_wmask_o
);

  // Read channel state
  logic [1:0]  r_state_q, r_state_d;
  logic [31:0] raddr_q, raddr_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        arready_q, arready_d;
  logic        r_in_range;

  // Write channel state
  logic [1:0]  w_state_q, w_state_d;
  logic [31:0] waddr_q, waddr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        w_in_range;
  logic        aw_got, w_got;
  logic [63:0] wmask;

  assign r_in_range = addr_in_range(raddr_q, BASE, SIZE);
  assign w_in_range = addr_in_range(waddr_q, BASE, SIZE);

  strb2mask u_strb2mask (
    .strb (wstrb_q),
    .mask (wmask)
  );

  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ram_ren_o = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          raddr_d   = araddr;
          r_state_d = R_ACCESS;
        end
      end
      R_ACCESS: begin
        if (!r_in_range) begin
          rdata_d   = '0;
          rresp_d   = RESP_SLVERR;
          r_state_d = R_RESP;
        end else if (w_state_q != W_ISSUE) begin
          // A colliding write owns this cycle; the read retries next cycle.
          ram_ren_o = 1'b1;
          rdata_d   = ram_rdata_i;
          rresp_d   = RESP_OKAY;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    bresp_d   = bresp_q;
    ram_wen_o = 1'b0;
    aw_got    = 1'b0;
    w_got     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_got = aw_held_q || (awvalid && awready_q);
        w_got  = w_held_q || (wvalid && wready_q);
        if (awvalid && awready_q) waddr_d = awaddr;
        if (wvalid && wready_q) begin
          wdata_d = wdata;
          wstrb_d = wstrb;
        end
        if (aw_got && w_got) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_ISSUE;
        end else begin
          aw_held_d = aw_got;
          w_held_d  = w_got;
        end
      end
      W_ISSUE: begin
        ram_wen_o = w_in_range;
        bresp_d   = w_in_range ? RESP_OKAY : RESP_SLVERR;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      arready_q <= arready_d;
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bresp_q   <= bresp_d;
    end
  end

  assign arready = arready_q;
  assign rvalid  = (r_state_q == R_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bresp_q;

  // Address/data/mask lines idle at zero whenever no access is issued.
  assign ram_raddr_o = ram_ren_o ? raddr_q : '0;
  assign ram_waddr_o = ram_wen_o ? waddr_q : '0;
  assign ram_wmask_o = ram_wen_o ? wmask : '0;
  // ram ORs the data in unmasked, so clear the unstrobed bytes here.
  assign ram_wdata_o = ram_wen_o ? (wdata_q & wmask) : '0;

endmodule

// File: tb/tb_axi_ram_bridge.sv
module tb_axi_ram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        ram_ren_o;
  logic [31:0] ram_raddr_o;
  logic [63:0] ram_rdata_i;
  logic        ram_wen_o;
  logic [31:0] ram_waddr_o;
  logic [63:0] ram_wdata_o;
  logic [63:0] ram_wmask_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Small RAM model: 16 words indexed by address bits [6:3]; data is ORed in
  // after clearing the masked bits.
  logic [63:0] mem [16];
  logic        load_en;
  logic [3:0]  load_idx;
  logic [63:0] load_val;

  always_ff @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_val;
    else if (ram_wen_o)
      mem[ram_waddr_o[6:3]] <= (mem[ram_waddr_o[6:3]] & ~ram_wmask_o) | ram_wdata_o;
  end
  assign ram_rdata_i = mem[ram_raddr_o[6:3]];

  always #5 clk = ~clk;

  axi_ram_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .awaddr      (awaddr),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wvalid      (wvalid),
    .wready      (wready),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .ram_ren_o   (ram_ren_o),
    .ram_raddr_o (ram_raddr_o),
    .ram_rdata_i (ram_rdata_i),
    .ram_wen_o   (ram_wen_o),
    .ram_waddr_o (ram_waddr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_wmask_o (ram_wmask_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; araddr = '0; arvalid = 0; rready = 0; awaddr = '0; awvalid = 0;
    wdata = '0; wstrb = '0; wvalid = 0; bready = 0; load_en = 0; load_idx = '0; load_val = '0;
    #1 rst = 1'b0;
    #2;
    n_cmp++;
    if ({arready, awready, wready, rvalid, bvalid, ram_ren_o, ram_wen_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {arready, awready, wready, rvalid, bvalid, ram_ren_o, ram_wen_o});
    end
    n_cmp++;
    if ({rdata, rresp, bresp, ram_wmask_o, ram_raddr_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b wmask=%h want all 0",
               rdata, rresp, bresp, ram_wmask_o);
    end
    // Preload the RAM model while the bridge is held in reset.
    for (int i = 0; i < 16; i++) begin
      load_en  = 1'b1;
      load_idx = 4'(i);
      case (i)
        2:       load_val = 64'h1122_3344_5566_7788;
        3:       load_val = 64'h5555_AAAA_0000_FFFF;
        4:       load_val = 64'hAAAA_AAAA_AAAA_AAAA;
        default: load_val = 64'h0;
      endcase
      tick();
    end
    load_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({arready, awready, wready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ready_early: got %b want 000", {arready, awready, wready});
    end
    tick();
    n_cmp++;
    if ({arready, awready, wready} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_ready_rise: got %b want 111", {arready, awready, wready});
    end
  endtask

  task automatic test_read();
    araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ram_ren_o, rvalid, arready} !== 3'b100) begin
      n_fail++;
      $display("FAIL read_issue: ren,rvalid,arready=%b want 100", {ram_ren_o, rvalid, arready});
    end
    n_cmp++;
    if (ram_raddr_o !== 32'h8000_0010) begin
      n_fail++;
      $display("FAIL read_raddr: got %h want 80000010", ram_raddr_o);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({rvalid, rresp, ram_ren_o} !== 4'b1000) begin
      n_fail++;
      $display("FAIL read_resp: rvalid,rresp,ren=%b want 1000", {rvalid, rresp, ram_ren_o});
    end
    n_cmp++;
    if (rdata !== 64'h1122_3344_5566_7788) begin
      n_fail++;
      $display("FAIL read_rdata: got %h want 1122334455667788", rdata);
    end
    n_cmp++;
    if (ram_raddr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL read_raddr_idle: got %h want 0", ram_raddr_o);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({rvalid, arready} !== 2'b01) begin
      n_fail++;
      $display("FAIL read_done: rvalid,arready=%b want 01", {rvalid, arready});
    end
  endtask

  task automatic test_write();
    wdata = 64'hFFFF_FFFF_FFFF_FFFF; wstrb = 8'h0F; wvalid = 1'b1; bready = 1'b1;
    tick();
    wvalid = 1'b0; awaddr = 32'h8000_0008; awvalid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({wready, awready, ram_wen_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL write_w_first: wready,awready,wen=%b want 010", {wready, awready, ram_wen_o});
    end
    tick();
    awvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ram_wen_o, bvalid, awready} !== 3'b100) begin
      n_fail++;
      $display("FAIL write_issue: wen,bvalid,awready=%b want 100", {ram_wen_o, bvalid, awready});
    end
    n_cmp++;
    if (ram_waddr_o !== 32'h8000_0008) begin
      n_fail++;
      $display("FAIL write_waddr: got %h want 80000008", ram_waddr_o);
    end
    n_cmp++;
    if (ram_wmask_o !== 64'h0000_0000_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL write_wmask: got %h want 00000000ffffffff", ram_wmask_o);
    end
    n_cmp++;
    if (ram_wdata_o !== 64'h0000_0000_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL write_wdata: got %h want 00000000ffffffff", ram_wdata_o);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({ram_wen_o, bvalid, bresp} !== 4'b0100) begin
      n_fail++;
      $display("FAIL write_resp: wen,bvalid,bresp=%b want 0100", {ram_wen_o, bvalid, bresp});
    end
    n_cmp++;
    if (ram_wmask_o !== 64'h0) begin
      n_fail++;
      $display("FAIL write_wmask_idle: got %h want 0", ram_wmask_o);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      n_fail++;
      $display("FAIL write_done: bvalid,awready,wready=%b want 011", {bvalid, awready, wready});
    end
  endtask

  task automatic test_out_of_range();
    // Read above the window
    araddr = 32'h9000_0000; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ram_ren_o !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_read_ren: got %b want 0", ram_ren_o);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({rvalid, rresp} !== 3'b110) begin
      n_fail++;
      $display("FAIL oor_read_resp: rvalid,rresp=%b want 110", {rvalid, rresp});
    end
    n_cmp++;
    if (rdata !== 64'h0) begin
      n_fail++;
      $display("FAIL oor_read_rdata: got %h want 0", rdata);
    end
    tick();
    // Highest in-range word: BASE + SIZE - 8
    araddr = 32'h807F_FFF8; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ram_ren_o !== 1'b1) begin
      n_fail++;
      $display("FAIL top_read_ren: got %b want 1", ram_ren_o);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({rvalid, rresp} !== 3'b100) begin
      n_fail++;
      $display("FAIL top_read_resp: rvalid,rresp=%b want 100", {rvalid, rresp});
    end
    tick();
    // Write just below BASE, AW and W together
    awaddr = 32'h7FFF_FFF8; awvalid = 1'b1; wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    wstrb = 8'hFF; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ram_wen_o, ram_wdata_o, ram_waddr_o} !== '0) begin
      n_fail++;
      $display("FAIL oor_write_wen: wen=%b waddr=%h wdata=%h want 0", ram_wen_o, ram_waddr_o,
               ram_wdata_o);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({bvalid, bresp} !== 3'b110) begin
      n_fail++;
      $display("FAIL oor_write_resp: bvalid,bresp=%b want 110", {bvalid, bresp});
    end
    tick();
  endtask

  task automatic test_collision();
    araddr = 32'h8000_0020; arvalid = 1'b1; rready = 1'b1;
    awaddr = 32'h8000_0020; awvalid = 1'b1; wdata = 64'h0123_4567_89AB_CDEF;
    wstrb = 8'hFF; wvalid = 1'b1; bready = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ram_wen_o, ram_ren_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL coll_priority: wen,ren=%b want 10", {ram_wen_o, ram_ren_o});
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({ram_ren_o, bvalid, rvalid} !== 3'b110) begin
      n_fail++;
      $display("FAIL coll_retry: ren,bvalid,rvalid=%b want 110", {ram_ren_o, bvalid, rvalid});
    end
    n_cmp++;
    if (ram_raddr_o !== 32'h8000_0020) begin
      n_fail++;
      $display("FAIL coll_raddr: got %h want 80000020", ram_raddr_o);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({rvalid, rresp} !== 3'b100) begin
      n_fail++;
      $display("FAIL coll_resp: rvalid,rresp=%b want 100", {rvalid, rresp});
    end
    n_cmp++;
    if (rdata !== 64'h0123_4567_89AB_CDEF) begin
      n_fail++;
      $display("FAIL coll_rdata: got %h want 0123456789abcdef", rdata);
    end
    tick();
  endtask

  task automatic test_backpressure();
    rready = 1'b0; bready = 1'b0;
    araddr = 32'h8000_0010; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    tick();
    // Just past the window: BASE + SIZE
    awaddr = 32'h8080_0000; awvalid = 1'b1; wdata = 64'h1; wstrb = 8'h3C; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rvalid, bvalid, arready, awready, wready} !== 5'b11000) begin
        n_fail++;
        $display("FAIL bp_ctrl[%0d]: rvalid,bvalid,arready,awready,wready=%b want 11000", i,
                 {rvalid, bvalid, arready, awready, wready});
      end
      n_cmp++;
      if ({rdata, rresp, bresp} !== {64'h1122_3344_5566_7788, 2'b00, 2'b10}) begin
        n_fail++;
        $display("FAIL bp_payload[%0d]: rdata=%h rresp=%b bresp=%b want 1122334455667788/00/10",
                 i, rdata, rresp, bresp);
      end
      tick();
    end
    rready = 1'b1; bready = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++;
    if ({rvalid, bvalid, arready, awready, wready} !== 5'b00111) begin
      n_fail++;
      $display("FAIL bp_release: rvalid,bvalid,arready,awready,wready=%b want 00111",
               {rvalid, bvalid, arready, awready, wready});
    end
  endtask

  task automatic test_reset_mid();
    rready = 1'b0;
    araddr = 32'h8000_0010; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if (rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: rvalid=%b want 1", rvalid);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({rvalid, arready, rdata} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_async: rvalid=%b arready=%b rdata=%h want 0", rvalid, arready, rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    araddr = 32'h8000_0018; arvalid = 1'b1; rready = 1'b1;
    tick();
    n_cmp++;
    if ({arready, rvalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_mid_ready: arready,rvalid=%b want 10", {arready, rvalid});
    end
    tick();
    arvalid = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if ({rvalid, rresp} !== 3'b100 || rdata !== 64'h5555_AAAA_0000_FFFF) begin
      n_fail++;
      $display("FAIL rst_mid_read: rvalid=%b rresp=%b rdata=%h want 1/00/5555aaaa0000ffff",
               rvalid, rresp, rdata);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({rvalid, arready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_mid_done: rvalid,arready=%b want 01", {rvalid, arready});
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_out_of_range();
    test_collision();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
